farm_cmd_arbiter: RTL and testbench
===================================

# farm_cmd_arbiter

Round-robin arbiter and sequencer that shares the ant-farm cell command bus among several requesters (user input, ant agents, world initializer). It selects one pending request, drives the 5-bit cell opcode to the addressed cell for a fixed hold window, then returns the bus to no-op. Invalid opcodes are rejected without touching the grid. It sits between the requester logic and the cell array's `command` inputs.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `ADDR_W`, 6, cell index width
- `HOLD_CYCLES`, 2, cycles the opcode is held on the bus (1..15)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset; synchronous and active-low, single clock domain
- `req`  in  NREQ  per-requester request level
- `req_cmd`  in  5*NREQ  opcode of requester i at bits [5i+4:5i]
- `req_addr`  in  ADDR_W*NREQ  target cell of requester i
- `cell_sel`  out  ADDR_W  addressed cell
- `cell_cmd`  out  5  opcode to cell array; 0 = no-op
- `cell_we`  out  1  high while `cell_cmd` is valid for `cell_sel`
- `done`  out  NREQ  one-cycle completion pulse, one-hot
- `err`  out  1  one-cycle pulse with `done` when the opcode was rejected
- `busy`  out  1  high whenever state is not IDLE

## Operation
- Valid opcodes 1..8: 1 empty, 2 ground, 3 tunnel, 4 queen, 5..8 contents (none / ant / sugar / sugar+ant). 0 and 9..31 are invalid.
- States: IDLE, DRIVE, CLEAR, REJECT.
- IDLE: if any `req` bit set, pick winner by round-robin starting from `rr_ptr`; latch winner index, opcode, address. Valid opcode -> DRIVE; invalid -> REJECT. No request -> stay.
- DRIVE: `cell_we`=1, `cell_cmd`=latched opcode, `cell_sel`=latched address; count `HOLD_CYCLES` cycles, then -> CLEAR.
- CLEAR: `cell_we`=0, `cell_cmd`=0, `done[winner]`=1 -> IDLE.
- REJECT: `done[winner]`=1, `err`=1, bus stays no-op -> IDLE.
- `rr_ptr` resets to 0; on leaving IDLE with a grant it becomes (winner+1) mod NREQ. Rejected grants also advance it.
- Request inputs are latched at grant; changes or deassertion of `req` after grant are ignored and the operation completes.
- A requester holding `req` high after its `done` is re-arbitrated normally; it cannot win twice in a row if another requester is pending.

## Timing
- Reset: state IDLE, `cell_cmd`=0, `cell_sel`=0, `cell_we`=0, `done`=0, `err`=0, `busy`=0, `rr_ptr`=0, counter 0.
- Request seen in IDLE at cycle t -> `cell_we` high cycles t+1..t+HOLD_CYCLES -> `done` at t+HOLD_CYCLES+1 -> IDLE at t+HOLD_CYCLES+2; earliest next grant sampled at t+HOLD_CYCLES+2.
- Invalid opcode: `done`+`err` at t+1, IDLE at t+2.
- Throughput: one command per HOLD_CYCLES+2 cycles; reject per 2 cycles.
- All outputs registered; `done` and `err` never exceed one cycle.
- `rst_n` low during DRIVE: next edge forces reset values; no `done` is issued for the aborted command.

## Configuration
- `FARM_ARB_QUEEN_PRIO_EN` defined: requester 0 has fixed top priority — if `req[0]` is set in IDLE it wins regardless of `rr_ptr`; `rr_ptr` is not advanced by a requester-0 grant. Remaining requesters rotate round-robin among themselves.
- Undefined: pure round-robin across all NREQ requesters, requester 0 treated like any other.

## Test plan
- Single request: `req`=0001, cmd 3, addr 5 at t -> `cell_we`=1, `cell_cmd`=3, `cell_sel`=5 at t+1,t+2; `done`=0001 at t+3; `err`=0.
- Fairness: `req`=1111 held, all cmd 2 -> `done` order 0,1,2,3,0 at cycles t+3, t+7, t+11, t+15, t+19.
- Reject: requester 2 cmd 12 -> `done`=0100 and `err`=1 at t+1, `cell_we` never high, `rr_ptr`=3 afterward.
- Latching: requester 1 grants cmd 6 addr 9, then drops `req` and changes `req_cmd` to 1 at t+1 -> bus still shows 6/9 for both DRIVE cycles, `done`=0010 at t+3.
- Reset mid-DRIVE: `rst_n` low at t+1 -> at next edge `cell_we`=0, `cell_cmd`=0, `busy`=0, no `done` pulse.
- With `FARM_ARB_QUEEN_PRIO_EN`: `req`=1011 held, `rr_ptr`=1 -> requester 0 wins every grant while `req[0]` high; drop `req[0]` -> grants go 1, 3, 1.

Source files
------------

// File: rtl/farm_cmd_arbiter.sv
// Round-robin arbiter/sequencer for the ant-farm cell command bus.
// Optional macro FARM_ARB_QUEEN_PRIO_EN gives requester 0 fixed top priority.
module farm_cmd_arbiter #(
    parameter int NREQ        = 4,
    parameter int ADDR_W      = 6,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [5*NREQ-1:0]      req_cmd,
    input  logic [ADDR_W*NREQ-1:0] req_addr,
    output logic [ADDR_W-1:0]      cell_sel,
    output logic [4:0]             cell_cmd,
    output logic                   cell_we,
    output logic [NREQ-1:0]        done,
    output logic                   err,
    output logic                   busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StDrive, StClear, StReject} state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win;
    logic [3:0]         cnt;

    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic               advance;
    logic [4:0]         grant_cmd;
    logic [ADDR_W-1:0]  grant_addr;
    logic               grant_valid;

    // Scan requesters starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        advance     = 1'b1;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_found && req[idx[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx[PTR_W-1:0];
            end
        end
`ifdef FARM_ARB_QUEEN_PRIO_EN
        // Queen requester pre-empts the rotation and leaves the pointer alone.
        if (req[0]) begin
            grant_idx = '0;
            advance   = 1'b0;
        end
`endif
    end

    assign next_ptr    = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    assign grant_cmd   = req_cmd[5*grant_idx +: 5];
    assign grant_addr  = req_addr[ADDR_W*grant_idx +: ADDR_W];
    assign grant_valid = (grant_cmd >= 5'd1) && (grant_cmd <= 5'd8);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= StIdle;
            rr_ptr   <= '0;
            win      <= '0;
            cnt      <= '0;
            cell_sel <= '0;
            cell_cmd <= '0;
            cell_we  <= 1'b0;
            done     <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (grant_found) begin
                        win  <= grant_idx;
                        busy <= 1'b1;
                        if (advance) begin
                            rr_ptr <= next_ptr;
                        end
                        if (grant_valid) begin
                            state    <= StDrive;
                            cell_we  <= 1'b1;
                            cell_cmd <= grant_cmd;
                            cell_sel <= grant_addr;
                            cnt      <= 4'd1;
                        end else begin
                            state           <= StReject;
                            done[grant_idx] <= 1'b1;
                            err             <= 1'b1;
                        end
                    end
                end
                StDrive: begin
                    if (cnt == 4'(HOLD_CYCLES)) begin
                        state     <= StClear;
                        cell_we   <= 1'b0;
                        cell_cmd  <= '0;
                        done[win] <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                StClear: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                StReject: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_farm_cmd_arbiter.sv
// Directed bench for farm_cmd_arbiter (NREQ=4, ADDR_W=6, HOLD_CYCLES=2).
module tb_farm_cmd_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 6;
    localparam int HOLD   = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [5*NREQ-1:0]      req_cmd = '0;
    logic [ADDR_W*NREQ-1:0] req_addr = '0;
    logic [ADDR_W-1:0]      cell_sel;
    logic [4:0]             cell_cmd;
    logic                   cell_we;
    logic [NREQ-1:0]        done;
    logic                   err;
    logic                   busy;

    int n_checks = 0;
    int n_fail   = 0;

    farm_cmd_arbiter #(
        .NREQ(NREQ),
        .ADDR_W(ADDR_W),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_cmd(req_cmd),
        .req_addr(req_addr),
        .cell_sel(cell_sel),
        .cell_cmd(cell_cmd),
        .cell_we(cell_we),
        .done(done),
        .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        req      = '0;
        req_cmd  = '0;
        req_addr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({cell_we, cell_cmd, cell_sel, done, err, busy} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_state: got we=%b cmd=%0d sel=%0d done=%b err=%b busy=%b, need all 0",
                     cell_we, cell_cmd, cell_sel, done, err, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        req_cmd[4:0] = 5'd3;
        req_addr[5:0] = 6'd5;
        for (int c = 1; c <= HOLD; c++) begin
            @(negedge clk);
            if (c == 1) req = '0;
            n_checks++;
            if ({cell_we, cell_cmd, cell_sel, busy, done, err} !== {1'b1, 5'd3, 6'd5, 1'b1, 4'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL single_drive c%0d: got we=%b cmd=%0d sel=%0d busy=%b done=%b err=%b, need 1/3/5/1/0000/0",
                         c, cell_we, cell_cmd, cell_sel, busy, done, err);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({cell_we, cell_cmd, done, err} !== {1'b0, 5'd0, 4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL single_done: got we=%b cmd=%0d done=%b err=%b, need 0/0/0001/0",
                     cell_we, cell_cmd, done, err);
        end
        @(negedge clk);
        n_checks++;
        if ({done, busy} !== 5'd0) begin
            n_fail++;
            $display("FAIL single_idle: got done=%b busy=%b, need 0000/0", done, busy);
        end
    endtask

    task automatic test_fairness();
        int n;
        logic [3:0] e;
        do_reset();
        for (int i = 0; i < NREQ; i++) req_cmd[5*i +: 5] = 5'd2;
        req = 4'b1111;
        n = 0;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (done !== 4'b0000) begin
                e = 4'b0001 << (n % 4);
                n_checks++;
                if (done !== e || c != 3 + 4 * n) begin
                    n_fail++;
                    $display("FAIL fairness_%0d: got done=%b at t+%0d, need %b at t+%0d",
                             n, done, c, e, 3 + 4 * n);
                end
                n++;
            end
        end
        req = '0;
        n_checks++;
        if (n != 5) begin
            n_fail++;
            $display("FAIL fairness_count: got %0d done pulses, need 5", n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reject();
        do_reset();
        req = 4'b0100;
        req_cmd[14:10] = 5'd12;
        @(negedge clk);
        req = '0;
        n_checks++;
        if ({done, err, cell_we, busy} !== {4'b0100, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reject_pulse: got done=%b err=%b we=%b busy=%b, need 0100/1/0/1",
                     done, err, cell_we, busy);
        end
        @(negedge clk);
        n_checks++;
        if ({done, err, cell_we, busy} !== 7'd0) begin
            n_fail++;
            $display("FAIL reject_idle: got done=%b err=%b we=%b busy=%b, need all 0",
                     done, err, cell_we, busy);
        end
        // Pointer should now be 3: requester 3 must win among 0,1,3.
        for (int i = 0; i < NREQ; i++) begin
            req_addr[ADDR_W*i +: ADDR_W] = ADDR_W'(10 + i);
            if (i != 2) req_cmd[5*i +: 5] = 5'd1;
        end
        req = 4'b1011;
        @(negedge clk);
        req = '0;
        n_checks++;
        if ({cell_we, cell_sel} !== {1'b1, 6'd13}) begin
            n_fail++;
            $display("FAIL reject_ptr_grant: got we=%b sel=%0d, need 1/13", cell_we, cell_sel);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (done !== 4'b1000) begin
            n_fail++;
            $display("FAIL reject_ptr_done: got done=%b, need 1000", done);
        end
        @(negedge clk);
    endtask

    task automatic test_latching();
        do_reset();
        req = 4'b0010;
        req_cmd[9:5] = 5'd6;
        req_addr[11:6] = 6'd9;
        for (int c = 1; c <= HOLD; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req = '0;
                req_cmd[9:5] = 5'd1;
            end
            n_checks++;
            if ({cell_we, cell_cmd, cell_sel} !== {1'b1, 5'd6, 6'd9}) begin
                n_fail++;
                $display("FAIL latch_drive c%0d: got we=%b cmd=%0d sel=%0d, need 1/6/9",
                         c, cell_we, cell_cmd, cell_sel);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({done, err} !== {4'b0010, 1'b0}) begin
            n_fail++;
            $display("FAIL latch_done: got done=%b err=%b, need 0010/0", done, err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drive();
        do_reset();
        req = 4'b0001;
        req_cmd[4:0] = 5'd3;
        req_addr[5:0] = 6'd5;
        @(negedge clk);
        n_checks++;
        if (cell_we !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: got we=%b, need 1", cell_we);
        end
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        n_checks++;
        if ({cell_we, cell_cmd, busy, done, err} !== 12'd0) begin
            n_fail++;
            $display("FAIL abort_reset: got we=%b cmd=%0d busy=%b done=%b err=%b, need all 0",
                     cell_we, cell_cmd, busy, done, err);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if ({done, busy, cell_we} !== 6'd0) begin
                n_fail++;
                $display("FAIL abort_no_done c%0d: got done=%b busy=%b we=%b, need 0",
                         c, done, busy, cell_we);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_de [5];
        exp_de = '{5'b00011, 5'b00000, 5'b00101, 5'b00000, 5'b00000};
        do_reset();
        req_cmd[4:0] = 5'd0;
        req_cmd[9:5] = 5'd20;
        req = 4'b0011;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 3) req = '0;
            n_checks++;
            if ({done, err} !== exp_de[c-1]) begin
                n_fail++;
                $display("FAIL b2b_reject t+%0d: got done=%b err=%b, need %b", c, done, err,
                         exp_de[c-1]);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got busy=%b, need 0", busy);
        end
    endtask

`ifdef FARM_ARB_QUEEN_PRIO_EN
    task automatic test_queen();
        int n;
        logic [3:0] exp_q [6];
        exp_q = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b1000, 4'b0010};
        do_reset();
        for (int i = 0; i < NREQ; i++) req_cmd[5*i +: 5] = 5'd4;
        req = 4'b1011;
        n = 0;
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            if (done !== 4'b0000) begin
                n_checks++;
                if (n > 5 || done !== exp_q[n] || c != 3 + 4 * n) begin
                    n_fail++;
                    $display("FAIL queen_%0d: got done=%b at t+%0d", n, done, c);
                end
                n++;
            end
            if (c == 11) req = 4'b1010;
        end
        req = '0;
        n_checks++;
        if (n != 6) begin
            n_fail++;
            $display("FAIL queen_count: got %0d done pulses, need 6", n);
        end
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
`ifdef FARM_ARB_QUEEN_PRIO_EN
        test_queen();
`else
        test_fairness();
`endif
        test_reject();
        test_latching();
        test_reset_mid_drive();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
